// File: rtl/spi_master_engine_if.sv
// spi_master_engine_if
// Byte-stream handshake between an upstream host and the SPI master engine.
// The host drives tx_*; the engine answers with tx_ready, rx_* and busy.
interface spi_master_engine_if;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       busy;

  modport master (
    output tx_valid, tx_data, tx_last,
    input  tx_ready, rx_valid, rx_data, busy
  );

  modport slave (
    input  tx_valid, tx_data, tx_last,
    output tx_ready, rx_valid, rx_data, busy
  );
endinterface

// File: rtl/spi_master_engine.sv
// spi_master_engine
// SPI mode-0 byte engine. One byte is 8 bits of (low phase, high phase),
// each phase CLK_DIV clk cycles long. MISO is sampled on the clk edge where
// SCK rises; MOSI advances on the clk edge where SCK falls. Between bytes of
// one frame the engine parks in HOLD with CS asserted; after a byte flagged
// tx_last it keeps CS low for CLK_DIV cycles, then high for CLK_DIV cycles.
// Build option: define SPI_LSB_FIRST_EN to shift LSB-first on MOSI and MISO
// (MSB-first when undefined); timing is unchanged.
module spi_master_engine #(
  parameter int CLK_DIV = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_master_engine_if.slave   host,
  output logic                 spi_sck,
  output logic                 spi_mosi,
  input  logic                 spi_miso,
  output logic                 spi_cs_n
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SHIFT   = 3'd1,
    ST_HOLD    = 3'd2,
    ST_CS_TAIL = 3'd3,
    ST_DESEL   = 3'd4
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t     state_r;
  state_t     state_next_s;
  logic [7:0] div_cnt_r;
  logic       sck_r;
  logic [2:0] bit_cnt_r;
  logic [7:0] tx_shift_r;
  logic [7:0] rx_shift_r;
  logic       last_r;
  logic       mosi_r;
  logic       cs_n_r;
  logic       busy_r;
  logic       rx_valid_r;
  logic [7:0] rx_data_r;

  logic       ready_s;
  logic       hs_s;
  logic       div_wrap_s;
  logic       rise_s;
  logic       fall_s;
  logic       byte_done_s;

  // Bit that goes on the wire first from a freshly loaded byte.
  function automatic logic first_bit_f(input logic [7:0] d);
`ifdef SPI_LSB_FIRST_EN
    return d[0];
`else
    return d[7];
`endif
  endfunction

  // Drop the bit just presented so the next one sits in the output position.
  function automatic logic [7:0] shift_out_f(input logic [7:0] d);
`ifdef SPI_LSB_FIRST_EN
    return {1'b0, d[7:1]};
`else
    return {d[6:0], 1'b0};
`endif
  endfunction

  // Append one received bit in wire order.
  function automatic logic [7:0] shift_in_f(input logic [7:0] d, input logic b);
`ifdef SPI_LSB_FIRST_EN
    return {b, d[7:1]};
`else
    return {d[6:0], b};
`endif
  endfunction

  // Next-state decode plus per-cycle strobes for the datapath.
  always_comb begin
    state_next_s = state_r;
    rise_s       = 1'b0;
    fall_s       = 1'b0;
    byte_done_s  = 1'b0;
    div_wrap_s   = (div_cnt_r == DIV_LAST);
    ready_s      = !rst && ((state_r == ST_IDLE) || (state_r == ST_HOLD));
    hs_s         = ready_s && host.tx_valid;
    case (state_r)
      ST_IDLE, ST_HOLD: begin
        if (hs_s) begin
          state_next_s = ST_SHIFT;
        end else begin
          state_next_s = state_r;
        end
      end
      ST_SHIFT: begin
        if (div_wrap_s && !sck_r) begin
          rise_s = 1'b1;
        end else if (div_wrap_s && sck_r) begin
          fall_s = 1'b1;
          if (bit_cnt_r == 3'd7) begin
            byte_done_s  = 1'b1;
            state_next_s = last_r ? ST_CS_TAIL : ST_HOLD;
          end else begin
            state_next_s = ST_SHIFT;
          end
        end else begin
          state_next_s = ST_SHIFT;
        end
      end
      ST_CS_TAIL: begin
        if (div_wrap_s) begin
          state_next_s = ST_DESEL;
        end else begin
          state_next_s = ST_CS_TAIL;
        end
      end
      ST_DESEL: begin
        if (div_wrap_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DESEL;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Phase divider and SCK generation; every timed state restarts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_r <= 8'd0;
      sck_r     <= 1'b0;
    end else if (hs_s) begin
      div_cnt_r <= 8'd0;
      sck_r     <= 1'b0;
    end else if ((state_r == ST_SHIFT) || (state_r == ST_CS_TAIL) || (state_r == ST_DESEL)) begin
      if (div_wrap_s) begin
        div_cnt_r <= 8'd0;
        sck_r     <= (state_r == ST_SHIFT) ? !sck_r : 1'b0;
      end else begin
        div_cnt_r <= div_cnt_r + 8'd1;
      end
    end else begin
      div_cnt_r <= 8'd0;
      sck_r     <= 1'b0;
    end
  end

  // Transmit shifter: load on handshake, advance MOSI on each SCK fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_shift_r <= 8'h00;
      bit_cnt_r  <= 3'd0;
      mosi_r     <= 1'b0;
      last_r     <= 1'b0;
    end else if (hs_s) begin
      tx_shift_r <= shift_out_f(host.tx_data);
      mosi_r     <= first_bit_f(host.tx_data);
      last_r     <= host.tx_last;
      bit_cnt_r  <= 3'd0;
    end else if (byte_done_s) begin
      mosi_r     <= 1'b0;
    end else if (fall_s) begin
      mosi_r     <= first_bit_f(tx_shift_r);
      tx_shift_r <= shift_out_f(tx_shift_r);
      bit_cnt_r  <= bit_cnt_r + 3'd1;
    end
  end

  // Receive shifter: sample MISO on SCK rise, publish on the final fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_shift_r <= 8'h00;
      rx_valid_r <= 1'b0;
      rx_data_r  <= 8'h00;
    end else begin
      rx_valid_r <= byte_done_s;
      if (rise_s) begin
        rx_shift_r <= shift_in_f(rx_shift_r, spi_miso);
      end
      if (byte_done_s) begin
        rx_data_r <= rx_shift_r;
      end
    end
  end

  // Chip select and busy follow the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_n_r <= 1'b1;
      busy_r <= 1'b0;
    end else begin
      cs_n_r <= (state_next_s == ST_IDLE) || (state_next_s == ST_DESEL);
      busy_r <= (state_next_s != ST_IDLE);
    end
  end

  assign host.tx_ready = ready_s;
  assign host.rx_valid = rx_valid_r;
  assign host.rx_data  = rx_data_r;
  assign host.busy     = busy_r;
  assign spi_sck       = sck_r;
  assign spi_mosi      = mosi_r;
  assign spi_cs_n      = cs_n_r;

endmodule

// File: tb/tb_spi_master_engine.sv
// tb_spi_master_engine
// Two engines: A (CLK_DIV=2, MISO looped back from MOSI) for timing, hold,
// ignore and reset scenarios; B (CLK_DIV=1, scripted slave) for back-to-back
// bytes. Received bytes are checked against a scoreboard queue per engine.
`timescale 1ns/1ps
module tb_spi_master_engine;

  localparam int DA = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_master_engine_if ifa ();
  spi_master_engine_if ifb ();

  logic sck_a, mosi_a, miso_a, cs_n_a;
  logic sck_b, mosi_b, miso_b, cs_n_b;

  spi_master_engine #(.CLK_DIV(DA)) u_dut_a (
    .clk(clk), .rst(rst), .host(ifa),
    .spi_sck(sck_a), .spi_mosi(mosi_a), .spi_miso(miso_a), .spi_cs_n(cs_n_a)
  );

  spi_master_engine #(.CLK_DIV(1)) u_dut_b (
    .clk(clk), .rst(rst), .host(ifb),
    .spi_sck(sck_b), .spi_mosi(mosi_b), .spi_miso(miso_b), .spi_cs_n(cs_n_b)
  );

  int n_vec  = 0;
  int n_miss = 0;

  logic [7:0] exp_q_a [$];
  logic [7:0] exp_q_b [$];

  int   rises_a = 0;
  int   rises_b = 0;
  int   cs_hi_b = 0;
  logic sck_a_q = 1'b0;
  logic sck_b_q = 1'b0;
  int   rise_idx_b = 0;

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Wire-order bit i of byte d.
  function automatic logic exp_bit_f(input logic [7:0] d, input int i);
    logic [2:0] k;
    k = 3'(i);
`ifdef SPI_LSB_FIRST_EN
    return d[k];
`else
    return d[3'd7 - k];
`endif
  endfunction

  // Scripted slave for engine B: 0x12 then 0x34, in wire order.
  function automatic logic slave_bit_f(input int idx);
    if (idx >= 16) return 1'b0;
    return exp_bit_f((idx < 8) ? 8'h12 : 8'h34, idx % 8);
  endfunction

  assign miso_a = mosi_a;
  assign miso_b = slave_bit_f(rise_idx_b);

  // Slave B advances one bit after each SCK rise.
  always @(posedge sck_b) rise_idx_b <= rise_idx_b + 1;

  // Monitors: SCK rise counts, CS-high count for B, and scoreboard compare.
  always @(negedge clk) begin
    sck_a_q <= sck_a;
    sck_b_q <= sck_b;
    if (sck_a === 1'b1 && sck_a_q === 1'b0) rises_a <= rises_a + 1;
    if (sck_b === 1'b1 && sck_b_q === 1'b0) rises_b <= rises_b + 1;
    if (cs_n_b === 1'b1) cs_hi_b <= cs_hi_b + 1;
    if (ifa.rx_valid === 1'b1) begin
      if (exp_q_a.size() == 0) check_vec("rx_a_spurious", 32'(ifa.rx_valid), 32'd0);
      else check_vec("rx_a_data", 32'(ifa.rx_data), 32'(exp_q_a.pop_front()));
    end
    if (ifb.rx_valid === 1'b1) begin
      if (exp_q_b.size() == 0) check_vec("rx_b_spurious", 32'(ifb.rx_valid), 32'd0);
      else check_vec("rx_b_data", 32'(ifb.rx_data), 32'(exp_q_b.pop_front()));
    end
  end

  // Offer a byte, wait (bounded) for the handshake edge, return at the
  // negedge of the first cycle after it. Loopback expectation pushed for A.
  task automatic send(input bit sel, input logic [7:0] d, input logic last,
                      input bit drop, input bit expect_rx);
    int n;
    n = 0;
    if (sel) begin
      ifb.tx_valid = 1'b1; ifb.tx_data = d; ifb.tx_last = last;
    end else begin
      ifa.tx_valid = 1'b1; ifa.tx_data = d; ifa.tx_last = last;
      if (expect_rx) exp_q_a.push_back(d);
    end
    while (((sel ? ifb.tx_ready : ifa.tx_ready) !== 1'b1) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) check_vec("hs_timeout", 32'(n), 32'd0);
    @(posedge clk);
    @(negedge clk);
    if (drop) begin
      if (sel) ifb.tx_valid = 1'b0;
      else ifa.tx_valid = 1'b0;
    end
  endtask

  // Cycle-by-cycle pin check of engine A from cycle T+1 for ncyc cycles.
  // Packed as {cs_n, sck, mosi, rx_valid, tx_ready, busy}; MOSI is only
  // constrained while bits are shifting or CS is high.
  task automatic trace_a(input string tag, input logic [7:0] d, input logic last,
                         input bit inject, input int ncyc);
    logic [5:0] exp_v;
    logic [5:0] obs_v;
    logic       mosi_care;
    int         ph;
    for (int k = 1; k <= ncyc; k++) begin
      mosi_care = 1'b0;
      if (k <= 16 * DA) begin
        ph = (k - 1) / DA;
        exp_v = {1'b0, ph[0], exp_bit_f(d, (k - 1) / (2 * DA)), 1'b0, 1'b0, 1'b1};
        mosi_care = 1'b1;
      end else if (k == 16 * DA + 1) begin
        exp_v = {1'b0, 1'b0, 1'b0, 1'b1, ~last, 1'b1};
      end else if (!last) begin
        exp_v = 6'b000011;
      end else if (k <= 17 * DA) begin
        exp_v = 6'b000001;
      end else if (k <= 18 * DA) begin
        exp_v = 6'b100001; mosi_care = 1'b1;
      end else begin
        exp_v = 6'b100010; mosi_care = 1'b1;
      end
      obs_v = {cs_n_a, sck_a, mosi_care ? mosi_a : 1'b0, ifa.rx_valid, ifa.tx_ready, ifa.busy};
      check_vec(tag, 32'(obs_v), 32'(exp_v));
      if (inject && k == 8) begin
        ifa.tx_valid = 1'b1; ifa.tx_data = 8'h55; ifa.tx_last = 1'b0;
      end else if (inject && k == 9) begin
        ifa.tx_valid = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  // Watchdog: the run must never hang.
  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, c0, n, cnt;
    logic prev;
    ifa.tx_valid = 1'b0; ifa.tx_data = 8'h00; ifa.tx_last = 1'b0;
    ifb.tx_valid = 1'b0; ifb.tx_data = 8'h00; ifb.tx_last = 1'b0;

    // Reset state.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_vec("rst_pins", 32'({cs_n_a, sck_a, mosi_a, ifa.rx_valid, ifa.busy, ifa.tx_ready}), 32'(6'b100000));
    check_vec("rst_rx_data", 32'(ifa.rx_data), 32'h00);
    rst = 1'b0;
    #1;
    check_vec("rel_ready", 32'(ifa.tx_ready), 32'd1);
    @(negedge clk);
    check_vec("idle_pins", 32'({cs_n_a, sck_a, ifa.busy, ifa.tx_ready}), 32'(4'b1001));

    // Single byte 0xA5 with tx_last.
    send(1'b0, 8'hA5, 1'b1, 1'b1, 1'b1);
    trace_a("t_single_a5", 8'hA5, 1'b1, 1'b0, 18 * DA + 1);

    // 0x01: first wire bit differs between MSB- and LSB-first builds.
    send(1'b0, 8'h01, 1'b1, 1'b1, 1'b1);
    trace_a("t_byte_01", 8'h01, 1'b1, 1'b0, 18 * DA + 1);

    // tx_last=0 then 100 idle cycles in HOLD, then closing byte from HOLD.
    send(1'b0, 8'h5A, 1'b0, 1'b1, 1'b1);
    trace_a("t_hold", 8'h5A, 1'b0, 1'b0, 16 * DA + 1 + 100);
    send(1'b0, 8'hC3, 1'b1, 1'b1, 1'b1);
    trace_a("t_from_hold", 8'hC3, 1'b1, 1'b0, 18 * DA + 1);

    // tx_valid pulsed mid-byte must be ignored.
    r0 = rises_a;
    send(1'b0, 8'h3C, 1'b1, 1'b1, 1'b1);
    trace_a("t_ignore", 8'h3C, 1'b1, 1'b1, 18 * DA + 10);
    check_vec("ignore_rises", 32'(rises_a - r0), 32'd8);
    check_vec("q_a_empty", 32'(exp_q_a.size()), 32'd0);

    // Reset at the 5th SCK rise of 0xFF, then a clean 0x81.
    send(1'b0, 8'hFF, 1'b1, 1'b1, 1'b0);
    cnt = 0; n = 0; prev = 1'b0;
    while (cnt < 5 && n < 200) begin
      if (sck_a === 1'b1 && prev === 1'b0) cnt++;
      prev = sck_a;
      if (cnt < 5) begin
        @(negedge clk);
        n++;
      end
    end
    if (n >= 200) check_vec("rise5_timeout", 32'(n), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check_vec("abort_pins", 32'({cs_n_a, sck_a, mosi_a, ifa.rx_valid, ifa.busy}), 32'(5'b10000));
    rst = 1'b0;
    #1;
    check_vec("abort_ready", 32'(ifa.tx_ready), 32'd1);
    @(negedge clk);
    send(1'b0, 8'h81, 1'b1, 1'b1, 1'b1);
    trace_a("t_after_abort", 8'h81, 1'b1, 1'b0, 18 * DA + 1);
    check_vec("q_a_drained", 32'(exp_q_a.size()), 32'd0);

    // Engine B: back-to-back 0x3C, 0xC3 with tx_valid held high.
    exp_q_b.push_back(8'h12);
    exp_q_b.push_back(8'h34);
    send(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    r0 = rises_b;
    c0 = cs_hi_b;
    send(1'b1, 8'hC3, 1'b1, 1'b1, 1'b0);
    repeat (16) @(negedge clk);
    check_vec("b2b_rises", 32'(rises_b - r0), 32'd16);
    check_vec("b2b_cs_high", 32'(cs_hi_b - c0), 32'd0);
    repeat (5) @(negedge clk);
    check_vec("q_b_drained", 32'(exp_q_b.size()), 32'd0);
    check_vec("b_idle_cs", 32'({cs_n_b, ifb.busy}), 32'(2'b10));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/spi_master_engine.md
SPI_MASTER_ENGINE -- requirements
Module: spi_master_engine

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; clock port clk, reset port rst.
REQ-002 SHALL have parameter CLK_DIV, default 2, giving the SCK half-period in clk cycles; legal values are 1..255.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 tx_valid  input  1  upstream offers a byte.
REQ-006 tx_ready  output  1  engine accepts a byte this cycle.
REQ-007 tx_data  input  8  byte to transmit.
REQ-008 tx_last  input  1  release CS after this byte; sampled with tx_data.
REQ-009 rx_valid  output  1  one-cycle pulse; rx_data is valid.
REQ-010 rx_data  output  8  byte received on MISO; holds until the next rx_valid.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 spi_sck  output  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-013 spi_mosi  output  1  SPI data out.
REQ-014 spi_miso  input  1  SPI data in.
REQ-015 spi_cs_n  output  1  active-low chip select.

Function
REQ-016 SHALL implement states IDLE, SHIFT, HOLD, CS_TAIL and DESEL.
REQ-017 A handshake SHALL occur when tx_valid=1 and tx_ready=1 at a rising edge; tx_data and tx_last SHALL be captured then, and ignored at all other times.
REQ-018 tx_ready SHALL be 1 only in IDLE and HOLD.
REQ-019 IDLE: cs_n=1, sck=0; on handshake at edge T go to SHIFT, with cs_n=0 and mosi=bit 7 from cycle T+1.
REQ-020 SHIFT: each bit SHALL be a low phase of CLK_DIV cycles followed by a high phase of CLK_DIV cycles, starting with the low phase.
REQ-021 spi_miso SHALL be captured into the receive shifter on the clk edge where sck goes 0->1.
REQ-022 mosi SHALL change only on the clk edge where sck goes 1->0, presenting the next bit.
REQ-023 A byte SHALL occupy exactly 16*CLK_DIV cycles; the first sck rise is at T+1+CLK_DIV and the final fall is at T+1+16*CLK_DIV.
REQ-024 On the cycle of the final fall, rx_valid SHALL be 1 and rx_data SHALL equal the 8 captured bits.
REQ-025 After the final fall with captured tx_last=0: enter HOLD with cs_n=0, sck=0, tx_ready=1; a handshake in HOLD SHALL start the next byte's low phase on the next cycle with no extra setup.
REQ-026 HOLD SHALL persist indefinitely with cs_n low until a handshake occurs.
REQ-027 After the final fall with captured tx_last=1: enter CS_TAIL with cs_n=0 for CLK_DIV cycles, then DESEL with cs_n=1 for CLK_DIV cycles, then IDLE.
REQ-028 Back-to-back handshakes (tx_valid held high) SHALL give continuous bytes: one HOLD cycle between a byte's final fall and the next byte's first low-phase cycle.
REQ-029 mosi SHALL be 0 whenever cs_n=1.
REQ-030 tx_valid asserted while tx_ready=0 SHALL have no effect.

Reset
REQ-031 While rst=1 and on the cycle after it is sampled, outputs SHALL be: cs_n=1, sck=0, mosi=0, rx_valid=0, rx_data=0x00, busy=0, tx_ready=0 while rst=1 and 1 on the first cycle after release.
REQ-032 rst asserted mid-byte SHALL abort the transfer immediately with no rx_valid pulse; state SHALL return to IDLE.

Configuration
REQ-033 Macro SPI_LSB_FIRST_EN: when defined, bits SHALL be shifted LSB-first on both MOSI and MISO; when undefined, MSB-first. Timing and all other behaviour SHALL be identical in both cases.

Verification
REQ-034 CLK_DIV=2, single byte tx_data=0xA5, tx_last=1, MISO loopback -> sck has 8 pulses; rx_valid at T+33 with rx_data=0xA5; cs_n low T+1..T+34, high from T+35; tx_ready returns at T+37.
REQ-035 CLK_DIV=1, bytes 0x3C and 0xC3 back-to-back, tx_last on the second only, slave returns 0x12 then 0x34 -> rx_data 0x12 then 0x34; cs_n stays continuously low across both bytes; exactly 16 sck rises.
REQ-036 tx_last=0 with no following tx_valid for 100 cycles -> cs_n stays 0, sck stays 0, busy=1, tx_ready=1 for all 100 cycles.
REQ-037 rst pulse at the 5th sck rise of byte 0xFF -> next cycle cs_n=1, sck=0, mosi=0; no rx_valid; a following byte 0x81 transfers correctly.
REQ-038 With SPI_LSB_FIRST_EN defined, tx_data=0x01 -> mosi=1 during the first bit only; slave MISO sequence 1,0,0,0,0,0,0,0 -> rx_data=0x01.
REQ-039 tx_valid pulsed during SHIFT with tx_data=0x55 -> ignored; the byte in flight completes unchanged and no extra byte is sent.
